// File: rtl/vga_pixel_prefetch_if.sv
// Bus bundle between the pixel prefetcher, the SDRAM Wishbone slave and the VGA timing stage.
// The master modport is the prefetcher's view.
interface vga_pixel_prefetch_if #(
    parameter int unsigned ADR_W = 32,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             wshb_cyc;
    logic             wshb_stb;
    logic             wshb_we;
    logic [1:0]       wshb_sel;
    logic [ADR_W-1:0] wshb_adr;
    logic [15:0]      wshb_dat_sm;
    logic             wshb_ack;

    logic             pix_rd;
    logic             pix_valid;
    logic [15:0]      pix_data;
    logic [LVL_W-1:0] fill_level;
    logic             underflow;

    modport master (
        output wshb_cyc, wshb_stb, wshb_we, wshb_sel, wshb_adr,
        input  wshb_dat_sm, wshb_ack,
        input  pix_rd,
        output pix_valid, pix_data, fill_level, underflow
    );

    modport slave (
        input  wshb_cyc, wshb_stb, wshb_we, wshb_sel, wshb_adr,
        output wshb_dat_sm, wshb_ack,
        output pix_rd,
        input  pix_valid, pix_data, fill_level, underflow
    );
endinterface

// File: rtl/vga_pixel_prefetch.sv
// Wishbone read master streaming the RGB565 framebuffer in raster order into a
// first-word-fall-through pixel FIFO consumed by the VGA timing stage.
module vga_pixel_prefetch #(
    parameter int unsigned HDISP = 640,
    parameter int unsigned VDISP = 480,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ADR_W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic frame_start,
    vga_pixel_prefetch_if.master bus
);
    localparam int unsigned NPIX  = HDISP * VDISP;
    localparam int unsigned IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             underflow_q, underflow_d;
    logic [15:0]      mem_q [DEPTH];

    logic stb_c, push_c, pop_c;

    // Strobe follows FIFO room; a frame_start drops any ack and pop landing with it.
    assign stb_c  = (state_q == FETCH) && (count_q < LVL_W'(DEPTH));
    assign push_c = stb_c && bus.wshb_ack && !frame_start;
    assign pop_c  = bus.pix_rd && valid_q && !frame_start;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q | (bus.pix_rd && !valid_q);

        unique case (state_q)
            IDLE:    if (enable) state_d = FETCH;
            // Leave only once no request is outstanding.
            FETCH:   if (!enable && !(stb_c && !bus.wshb_ack)) state_d = IDLE;
            FLUSH:   state_d = enable ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            index_d  = (index_q == IDX_W'(NPIX - 1)) ? '0 : index_q + IDX_W'(1);
        end
        if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase

        if (frame_start) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            index_d  = '0;
            state_d  = (state_q == IDLE) ? IDLE : FLUSH;
        end

        adr_d   = ADR_W'({index_d, 1'b0});
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            index_q     <= '0;
            adr_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            adr_q       <= adr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= bus.wshb_dat_sm;
    end

    assign bus.wshb_cyc   = stb_c;
    assign bus.wshb_stb   = stb_c;
    assign bus.wshb_we    = 1'b0;
    assign bus.wshb_sel   = 2'b11;
    assign bus.wshb_adr   = adr_q;
    assign bus.pix_valid  = valid_q;
    assign bus.pix_data   = mem_q[rd_ptr_q];
    assign bus.fill_level = count_q;
    assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// Directed bench for vga_pixel_prefetch: a vector table plus hand-written corner sequences,
// with a second small-frame instance for address wrap.
module tb_vga_pixel_prefetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, fs = 1'b0;
    logic en_s = 1'b0, fs_s = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_pixel_prefetch_if #(.ADR_W(32), .DEPTH(16)) bus ();
    vga_pixel_prefetch_if #(.ADR_W(32), .DEPTH(16)) sbus ();

    vga_pixel_prefetch #(.HDISP(640), .VDISP(480), .DEPTH(16), .ADR_W(32)) dut (
        .clk(clk), .rst(rst), .enable(en), .frame_start(fs), .bus(bus.master));

    vga_pixel_prefetch #(.HDISP(4), .VDISP(2), .DEPTH(16), .ADR_W(32)) dut_s (
        .clk(clk), .rst(rst), .enable(en_s), .frame_start(fs_s), .bus(sbus.master));

    typedef struct {
        logic        en, fs, ack;
        logic [15:0] dat;
        logic        rd;
        logic        e_stb;
        logic [31:0] e_adr;
        logic [4:0]  e_lvl;
        logic        e_val;
        logic [15:0] e_data;
        logic        e_uf;
    } vec_t;

    vec_t tv [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs for one cycle; return 1 time unit after the edge.
    task automatic step(input logic en_i, input logic fs_i, input logic ack_i,
                        input logic [15:0] dat_i, input logic rd_i);
        en = en_i;
        fs = fs_i;
        bus.wshb_ack = ack_i;
        bus.wshb_dat_sm = dat_i;
        bus.pix_rd = rd_i;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        fs = 1'b0;
        bus.wshb_ack = 1'b0;
        bus.wshb_dat_sm = '0;
        bus.pix_rd = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        sbus.wshb_ack = 1'b0;
        sbus.wshb_dat_sm = '0;
        sbus.pix_rd = 1'b0;

        tv[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'd0, 5'd0, 1'b0, 16'h0000, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 32'd2, 5'd1, 1'b1, 16'h1111, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 32'd4, 5'd2, 1'b1, 16'h1111, 1'b0};
        tv[3]  = '{1'b1, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 32'd6, 5'd2, 1'b1, 16'h2222, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 32'd6, 5'd1, 1'b1, 16'h3333, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'd6, 5'd1, 1'b1, 16'h3333, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 16'h4444, 1'b0, 1'b0, 32'd8, 5'd2, 1'b1, 16'h3333, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'd8, 5'd1, 1'b1, 16'h4444, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'd8, 5'd0, 1'b0, 16'h0000, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'd8, 5'd0, 1'b0, 16'h0000, 1'b1};
        tv[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'd8, 5'd0, 1'b0, 16'h0000, 1'b1};
        tv[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 16'h0000, 1'b1};
        tv[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'd0, 5'd0, 1'b0, 16'h0000, 1'b1};
        tv[13] = '{1'b1, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b1, 32'd2, 5'd1, 1'b1, 16'h5555, 1'b1};

        // Reset state
        do_reset();
        chk("rst_stb", 32'(bus.wshb_stb), 32'd0);
        chk("rst_cyc", 32'(bus.wshb_cyc), 32'd0);
        chk("rst_adr", bus.wshb_adr, 32'd0);
        chk("rst_lvl", 32'(bus.fill_level), 32'd0);
        chk("rst_valid", 32'(bus.pix_valid), 32'd0);
        chk("rst_uf", 32'(bus.underflow), 32'd0);
        chk("we", 32'(bus.wshb_we), 32'd0);
        chk("sel", 32'(bus.wshb_sel), 32'd3);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            step(tv[i].en, tv[i].fs, tv[i].ack, tv[i].dat, tv[i].rd);
            chk($sformatf("tv%0d_stb", i), 32'(bus.wshb_stb), 32'(tv[i].e_stb));
            chk($sformatf("tv%0d_cyc", i), 32'(bus.wshb_cyc), 32'(tv[i].e_stb));
            chk($sformatf("tv%0d_adr", i), bus.wshb_adr, tv[i].e_adr);
            chk($sformatf("tv%0d_lvl", i), 32'(bus.fill_level), 32'(tv[i].e_lvl));
            chk($sformatf("tv%0d_valid", i), 32'(bus.pix_valid), 32'(tv[i].e_val));
            if (tv[i].e_val) chk($sformatf("tv%0d_data", i), 32'(bus.pix_data), 32'(tv[i].e_data));
            chk($sformatf("tv%0d_uf", i), 32'(bus.underflow), 32'(tv[i].e_uf));
        end

        // Fill to DEPTH with no pops: stb drops at 16, no 17th push
        do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i < 16) begin
                chk($sformatf("fill%0d_stb", i), 32'(bus.wshb_stb), 32'd1);
                chk($sformatf("fill%0d_adr", i), bus.wshb_adr, 32'(2 * i));
            end else begin
                chk($sformatf("fill%0d_stb", i), 32'(bus.wshb_stb), 32'd0);
            end
            step(1'b1, 1'b0, 1'b1, 16'(16'h0100 + i), 1'b0);
        end
        chk("fill_lvl", 32'(bus.fill_level), 32'd16);
        chk("fill_adr", bus.wshb_adr, 32'd32);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_data", i), 32'(bus.pix_data), 32'(16'h0100 + i));
            step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        end
        chk("drain_lvl", 32'(bus.fill_level), 32'd0);
        chk("drain_uf", 32'(bus.underflow), 32'd0);

        // Streaming: push and pop every cycle
        do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'hA000, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("stream%0d_data", k), 32'(bus.pix_data), 32'(16'hA000 + k - 1));
            chk($sformatf("stream%0d_lvl", k), 32'(bus.fill_level), 32'd1);
            step(1'b1, 1'b0, 1'b1, 16'(16'hA000 + k), 1'b1);
        end
        chk("stream_uf", 32'(bus.underflow), 32'd0);

        // frame_start colliding with ack at level 5
        do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 16'(16'h0010 + i), 1'b0);
        chk("fs_pre_lvl", 32'(bus.fill_level), 32'd5);
        step(1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b1);
        chk("fs_lvl", 32'(bus.fill_level), 32'd0);
        chk("fs_valid", 32'(bus.pix_valid), 32'd0);
        chk("fs_flush_stb", 32'(bus.wshb_stb), 32'd0);
        chk("fs_adr", bus.wshb_adr, 32'd0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("fs_fetch_stb", 32'(bus.wshb_stb), 32'd1);
        chk("fs_fetch_adr", bus.wshb_adr, 32'd0);
        step(1'b1, 1'b0, 1'b1, 16'h0042, 1'b0);
        chk("fs_next_data", 32'(bus.pix_data), 32'h0042);
        chk("fs_next_lvl", 32'(bus.fill_level), 32'd1);

        // Async reset mid-request
        do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h0001, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h0002, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("arst_pre_stb", 32'(bus.wshb_stb), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_stb", 32'(bus.wshb_stb), 32'd0);
        chk("arst_cyc", 32'(bus.wshb_cyc), 32'd0);
        chk("arst_adr", bus.wshb_adr, 32'd0);
        chk("arst_lvl", 32'(bus.fill_level), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        en = 1'b0;

        // Small frame (4x2): addresses wrap after 16 bytes without a gap
        en_s = 1'b1;
        @(posedge clk);
        #1;
        sbus.wshb_ack = 1'b1;
        sbus.pix_rd = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sbus.wshb_dat_sm = 16'(k);
            chk($sformatf("wrap%0d_stb", k), 32'(sbus.wshb_stb), 32'd1);
            chk($sformatf("wrap%0d_adr", k), sbus.wshb_adr, 32'((2 * k) % 16));
            @(posedge clk);
            #1;
        end
        sbus.wshb_ack = 1'b0;
        sbus.pix_rd = 1'b0;
        en_s = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
